// File: rtl/lsu_rib_master.sv
// Load/store master for the RIB bus: one word access per request, grant/ack
// handshake, timeout abort, and a pipeline stall while the access is in flight.
module lsu_rib_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              done_o,
  output logic              err_o,
  output logic              hold_o,
  output logic              rib_req_o,
  output logic              rib_we_o,
  output logic [ADDR_W-1:0] rib_addr_o,
  output logic [DATA_W-1:0] rib_wdata_o,
  input  logic              rib_gnt_i,
  input  logic              rib_ack_i,
  input  logic [DATA_W-1:0] rib_rdata_i
);

  localparam int unsigned LSB_W = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((2 ** LSB_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q;
  logic            busy_c;
  logic            ack_c;
  logic            timeout_c;
  logic            req_d;

  assign busy_c    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign timeout_c = busy_c && (cnt_q == TO_W'(TIMEOUT - 1));

  // Next state; a same-cycle ack takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    ack_c   = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid_i) state_d = S_REQ;
      S_REQ: begin
        ack_c = rib_gnt_i & rib_ack_i;
        if (ack_c)          state_d = S_DONE;
        else if (timeout_c) state_d = S_ERR;
        else if (rib_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        ack_c = rib_ack_i;
        if (ack_c)          state_d = S_DONE;
        else if (timeout_c) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_d  = (state_d == S_REQ) || (state_d == S_WAIT);
  assign hold_o = ((state_q == S_IDLE) && req_valid_i) || busy_c;

  // State, counter and registered outputs; bus regs double as the request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rib_req_o   <= 1'b0;
      rib_we_o    <= 1'b0;
      rib_addr_o  <= '0;
      rib_wdata_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= busy_c ? cnt_q + TO_W'(1) : '0;
      rib_req_o <= req_d;
      done_o    <= (state_d == S_DONE);
      err_o     <= (state_d == S_ERR);

      if ((state_q == S_IDLE) && req_d) begin
        rib_we_o    <= req_we_i;
        rib_addr_o  <= req_addr_i & ALIGN_MASK;
        rib_wdata_o <= req_wdata_i;
      end else if (!req_d) begin
        rib_we_o    <= 1'b0;
        rib_addr_o  <= '0;
        rib_wdata_o <= '0;
      end

      if (ack_c && !rib_we_o) rd_data_o <= rib_rdata_i;
      else if (state_d == S_ERR) rd_data_o <= '0;
    end
  end

endmodule
